// File: rtl/rv4028_mem_target.sv
// RV4028 memory-bus target: decodes mreq_n cycles in an address window, serves them
// from a 16-bit byte-maskable RAM, and stretches each access with WAIT_STATES wait cycles.
module rv4028_mem_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [1:0]  msk_n,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        wait_n,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [15:0]          ram [2**ADDR_BITS];

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [ADDR_BITS-1:0] idx, idx_nxt;
  logic                 is_rd, is_rd_nxt;
  logic                 err_seen, err_seen_nxt;
  logic                 wait_nxt, oe_nxt, perr_nxt;
  logic                 load_rd, ram_we;
  logic [ADDR_BITS-1:0] req_idx, rd_idx;
  logic                 addr_hit, strobe_one, strobe_both, req_ok;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = addr[0];
  assign req_idx     = addr[ADDR_BITS:1];
  assign addr_hit    = (addr[31:ADDR_BITS+1] == BASE_ADDR[31:ADDR_BITS+1]);
  assign strobe_one  = rd_n ^ wr_n;
  assign strobe_both = !rd_n && !wr_n;
  assign req_ok      = !mreq_n && iorq_n && strobe_one && addr_hit;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    is_rd_nxt    = is_rd;
    wait_nxt     = 1'b1;
    oe_nxt       = 1'b0;
    perr_nxt     = 1'b0;
    load_rd      = 1'b0;
    ram_we       = 1'b0;
    rd_idx       = idx;
    // err_seen limits proto_err to one pulse per mreq_n assertion
    err_seen_nxt = err_seen && !mreq_n;

    unique case (state)
      ST_IDLE: begin
        rd_idx = req_idx;
        if (req_ok) begin
          idx_nxt   = req_idx;
          is_rd_nxt = !rd_n;
          ram_we    = !wr_n;
          if (WAIT_STATES == 0) begin
            state_nxt = ST_HOLD;
            load_rd   = !rd_n;
            oe_nxt    = !rd_n;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WS_INIT;
            wait_nxt  = 1'b0;
          end
        end else if (!mreq_n && iorq_n && strobe_both && !err_seen) begin
          perr_nxt     = 1'b1;
          err_seen_nxt = 1'b1;
        end
      end

      ST_WAIT: begin
        if (mreq_n) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt = ST_HOLD;
          load_rd   = is_rd;
          oe_nxt    = is_rd;
        end else begin
          cnt_nxt  = cnt - 4'd1;
          wait_nxt = 1'b0;
        end
      end

      ST_HOLD: begin
        if (mreq_n) begin
          state_nxt = ST_IDLE;
        end else begin
          oe_nxt = is_rd;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      idx       <= '0;
      is_rd     <= 1'b0;
      err_seen  <= 1'b0;
      wait_n    <= 1'b1;
      data_oe   <= 1'b0;
      proto_err <= 1'b0;
      data_out  <= 16'h0000;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      is_rd     <= is_rd_nxt;
      err_seen  <= err_seen_nxt;
      wait_n    <= wait_nxt;
      data_oe   <= oe_nxt;
      proto_err <= perr_nxt;
      if (load_rd) begin
        data_out <= ram[rd_idx];
      end
    end
  end

  // RAM has no reset; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (ram_we && rst_n) begin
      if (!msk_n[0]) ram[req_idx][7:0]  <= data_in[7:0];
      if (!msk_n[1]) ram[req_idx][15:8] <= data_in[15:8];
    end
  end

endmodule

// File: tb/tb_rv4028_mem_target.sv
// Bench for rv4028_mem_target: three instances (1, 3 and 0 wait states) driven by
// directed and randomized bus cycles, checked against a word-array memory model.
module tb_rv4028_mem_target;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr      [3];
  logic        mreq_n    [3];
  logic        iorq_n    [3];
  logic        rd_n      [3];
  logic        wr_n      [3];
  logic [1:0]  msk_n     [3];
  logic [15:0] data_in   [3];
  logic [15:0] data_out  [3];
  logic        data_oe   [3];
  logic        wait_n    [3];
  logic        proto_err [3];

  logic [15:0] mdl [3][1024];
  int n_chk;
  int n_pass;

  rv4028_mem_target #(.BASE_ADDR(32'h0), .ADDR_BITS(10), .WAIT_STATES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr[0]), .mreq_n(mreq_n[0]), .iorq_n(iorq_n[0]),
    .rd_n(rd_n[0]), .wr_n(wr_n[0]), .msk_n(msk_n[0]), .data_in(data_in[0]),
    .data_out(data_out[0]), .data_oe(data_oe[0]), .wait_n(wait_n[0]), .proto_err(proto_err[0]));

  rv4028_mem_target #(.BASE_ADDR(32'h0), .ADDR_BITS(10), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr[1]), .mreq_n(mreq_n[1]), .iorq_n(iorq_n[1]),
    .rd_n(rd_n[1]), .wr_n(wr_n[1]), .msk_n(msk_n[1]), .data_in(data_in[1]),
    .data_out(data_out[1]), .data_oe(data_oe[1]), .wait_n(wait_n[1]), .proto_err(proto_err[1]));

  rv4028_mem_target #(.BASE_ADDR(32'h0), .ADDR_BITS(10), .WAIT_STATES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .addr(addr[2]), .mreq_n(mreq_n[2]), .iorq_n(iorq_n[2]),
    .rd_n(rd_n[2]), .wr_n(wr_n[2]), .msk_n(msk_n[2]), .data_in(data_in[2]),
    .data_out(data_out[2]), .data_oe(data_oe[2]), .wait_n(wait_n[2]), .proto_err(proto_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] m);
    logic [15:0] lo, hi;
    lo = m[0] ? (old_w & 16'h00FF) : (new_w & 16'h00FF);
    hi = m[1] ? (old_w & 16'hFF00) : (new_w & 16'hFF00);
    return hi | lo;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic bus_idle(input int d);
    mreq_n[d] = 1'b1;
    iorq_n[d] = 1'b1;
    rd_n[d]   = 1'b1;
    wr_n[d]   = 1'b1;
  endtask

  // Called at a negedge; drives one complete cycle and returns at a negedge with the bus idle.
  task automatic do_access(input int d, input bit wr, input logic [31:0] a, input logic [1:0] m,
                           input logic [15:0] wd, input bit io_n, input string tag);
    bit          hit;
    bit          rd_hit;
    logic [15:0] exp_rd;
    int          nw;
    hit    = io_n && (a[31:11] == 21'd0);
    rd_hit = hit && !wr;
    exp_rd = mdl[d][a[10:1]];
    addr[d]    = a;
    rd_n[d]    = wr;
    wr_n[d]    = !wr;
    msk_n[d]   = m;
    data_in[d] = wd;
    iorq_n[d]  = io_n;
    mreq_n[d]  = 1'b0;
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wait_n[d] !== 1'b0) break;
      nw++;
    end
    check({tag, "/waits"}, 32'(nw), hit ? 32'(ws_of(d)) : 32'd0);
    check({tag, "/oe"}, {31'd0, data_oe[d]}, {31'd0, rd_hit});
    if (rd_hit) check({tag, "/data"}, {16'd0, data_out[d]}, {16'd0, exp_rd});
    @(negedge clk);
    check({tag, "/oe_hold"}, {31'd0, data_oe[d]}, {31'd0, rd_hit});
    if (rd_hit) check({tag, "/data_hold"}, {16'd0, data_out[d]}, {16'd0, exp_rd});
    bus_idle(d);
    @(negedge clk);
    check({tag, "/oe_release"}, {31'd0, data_oe[d]}, 32'd0);
    check({tag, "/wait_release"}, {31'd0, wait_n[d]}, 32'd1);
    if (hit && wr) mdl[d][a[10:1]] = merge(mdl[d][a[10:1]], wd, m);
  endtask

  initial begin
    int          pulses;
    int          wlow;
    int          oe_seen;
    int          op;
    logic [9:0]  ix;
    logic [31:0] a;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      bus_idle(d);
      addr[d]    = 32'h0;
      msk_n[d]   = 2'b00;
      data_in[d] = 16'h0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset%0d/wait_n", d), {31'd0, wait_n[d]}, 32'd1);
      check($sformatf("reset%0d/oe", d), {31'd0, data_oe[d]}, 32'd0);
      check($sformatf("reset%0d/data", d), {16'd0, data_out[d]}, 32'd0);
      check($sformatf("reset%0d/perr", d), {31'd0, proto_err[d]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Write/read and byte lanes on the 1-wait-state target
    do_access(0, 1'b1, 32'h10, 2'b00, 16'hA55A, 1'b1, "wr_a55a");
    do_access(0, 1'b0, 32'h10, 2'b00, 16'h0000, 1'b1, "rd_a55a");
    check("rd_a55a/value", {16'd0, data_out[0]}, 32'hA55A);
    do_access(0, 1'b1, 32'h20, 2'b00, 16'h1234, 1'b1, "wr_1234");
    do_access(0, 1'b1, 32'h20, 2'b10, 16'hFFFF, 1'b1, "wr_lane0");
    do_access(0, 1'b0, 32'h20, 2'b11, 16'h0000, 1'b1, "rd_12ff");
    check("rd_12ff/value", {16'd0, data_out[0]}, 32'h12FF);
    do_access(0, 1'b1, 32'h20, 2'b11, 16'h0000, 1'b1, "wr_nomask");
    do_access(0, 1'b0, 32'h21, 2'b00, 16'h0000, 1'b1, "rd_nomask");
    check("rd_nomask/value", {16'd0, data_out[0]}, 32'h12FF);

    // Decode filtering
    do_access(0, 1'b0, 32'h800, 2'b00, 16'h0000, 1'b1, "rd_miss");
    do_access(0, 1'b0, 32'h10, 2'b00, 16'h0000, 1'b0, "rd_iorq");

    // Both strobes low: one proto_err pulse, nothing else
    addr[0] = 32'h10; data_in[0] = 16'h0000; msk_n[0] = 2'b00;
    rd_n[0] = 1'b0; wr_n[0] = 1'b0; mreq_n[0] = 1'b0;
    pulses = 0; wlow = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (proto_err[0] === 1'b1) pulses++;
      if (wait_n[0] !== 1'b1) wlow++;
    end
    check("perr/pulses", 32'(pulses), 32'd1);
    check("perr/no_wait", 32'(wlow), 32'd0);
    bus_idle(0);
    @(negedge clk);
    do_access(0, 1'b0, 32'h10, 2'b00, 16'h0000, 1'b1, "perr_ram");
    check("perr_ram/value", {16'd0, data_out[0]}, 32'hA55A);

    // Abort during wait states on the 3-wait-state target
    addr[1] = 32'h10; rd_n[1] = 1'b0; wr_n[1] = 1'b1; mreq_n[1] = 1'b0;
    @(negedge clk);
    check("abort/wait_low", {31'd0, wait_n[1]}, 32'd0);
    bus_idle(1);
    @(negedge clk);
    check("abort/wait_high", {31'd0, wait_n[1]}, 32'd1);
    oe_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (data_oe[1] !== 1'b0) oe_seen++;
      @(negedge clk);
    end
    check("abort/oe_never", 32'(oe_seen), 32'd0);

    // Zero-wait back-to-back reads, one mreq_n-high cycle apart
    do_access(2, 1'b1, 32'h02, 2'b00, 16'hBEEF, 1'b1, "z_wr02");
    do_access(2, 1'b1, 32'h04, 2'b00, 16'hC0DE, 1'b1, "z_wr04");
    do_access(2, 1'b0, 32'h02, 2'b00, 16'h0000, 1'b1, "z_rd02");
    check("z_rd02/value", {16'd0, data_out[2]}, 32'hBEEF);
    do_access(2, 1'b0, 32'h04, 2'b00, 16'h0000, 1'b1, "z_rd04");
    check("z_rd04/value", {16'd0, data_out[2]}, 32'hC0DE);

    // Randomized traffic on all three targets
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++)
        do_access(d, 1'b1, 32'((32 + i) * 2), 2'b00, 16'($urandom()), 1'b1,
                  $sformatf("init%0d_%0d", d, i));
      for (int i = 0; i < 40; i++) begin
        op = int'($urandom_range(0, 3));
        ix = 10'(32 + $urandom_range(0, 7));
        a  = {21'd0, ix, 1'b0} | 32'($urandom_range(0, 1));
        case (op)
          0: do_access(d, 1'b1, a, 2'($urandom()), 16'($urandom()), 1'b1,
                       $sformatf("rnd%0d_%0d_wr", d, i));
          1: do_access(d, 1'b0, a, 2'($urandom()), 16'h0, 1'b1,
                       $sformatf("rnd%0d_%0d_rd", d, i));
          2: do_access(d, 1'($urandom()), ($urandom() & 32'hFFFF_F800) | 32'h800 | a,
                       2'b00, 16'($urandom()), 1'b1, $sformatf("rnd%0d_%0d_miss", d, i));
          default: do_access(d, 1'($urandom()), a, 2'b00, 16'($urandom()), 1'b0,
                             $sformatf("rnd%0d_%0d_iorq", d, i));
        endcase
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
